// File: rtl/down_cnt_pkg.sv
// Shared types for the down-counter wrap monitor: 2-bit count value, FSM states
// and the per-sample step classification.
package down_cnt_pkg;

    typedef logic [1:0] cnt2_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_ALERT = 2'd2,
        ST_ERROR = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        STEP_HOLD    = 2'd0,
        STEP_DEC     = 2'd1,
        STEP_WRAP    = 2'd2,
        STEP_ILLEGAL = 2'd3
    } step_t;

endpackage

// File: rtl/down_step_classify.sv
// Combinational decode of one down-counter sample against the previous sample:
// hold, single decrement, 00->11 wrap, or illegal jump.
module down_step_classify
    import down_cnt_pkg::*;
(
    input  cnt2_t prev,
    input  cnt2_t q_in,
    output step_t kind
);

    cnt2_t dec;

    assign dec = prev - 2'd1;

    always_comb begin
        // NOTE: assign a default before any branch so no path leaves kind unassigned (avoids a latch).
        kind = STEP_ILLEGAL;
        if (q_in == prev) begin
            kind = STEP_HOLD;
        end else if (q_in == dec) begin
            kind = (prev == 2'b00) ? STEP_WRAP : STEP_DEC;
        end
    end

endmodule

// File: rtl/down_wrap_monitor.sv
// Watches a 2-bit down counter, counts 00->11 wraps and raises irq at WRAP_LIMIT.
// Define DOWN_WRAP_SEQ_CHECK_EN to enable illegal-step detection (seq_err, ERROR state).
module down_wrap_monitor
    import down_cnt_pkg::*;
#(
    parameter int WRAP_W     = 8,
    parameter int WRAP_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [1:0]        q_in,
    input  logic              clr,
    input  logic              irq_ack,
    output logic              wrap_pulse,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic              irq,
    output logic              seq_err
);

    localparam logic [WRAP_W-1:0] CNT_MAX = '1;
    localparam logic [WRAP_W-1:0] CNT_ONE = WRAP_W'(1);
    localparam logic [WRAP_W-1:0] LIMIT   = WRAP_W'(WRAP_LIMIT);

    state_t            state;
    cnt2_t             prev;
    step_t             kind;
    logic [WRAP_W-1:0] cnt_inc;
    logic              ack_hit;

    down_step_classify u_classify (
        .prev (prev),
        .q_in (q_in),
        .kind (kind)
    );

    assign cnt_inc = (wrap_cnt == CNT_MAX) ? wrap_cnt : wrap_cnt + CNT_ONE;
    assign ack_hit = (state == ST_ALERT) && irq_ack;

`ifndef DOWN_WRAP_SEQ_CHECK_EN
    assign seq_err = 1'b0;
`endif

    // NOTE: every register here uses <= so all state updates see the pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            prev       <= 2'b00;
            wrap_cnt   <= '0;
            wrap_pulse <= 1'b0;
            irq        <= 1'b0;
`ifdef DOWN_WRAP_SEQ_CHECK_EN
            seq_err    <= 1'b0;
`endif
        end else if (clr) begin
            state      <= ST_IDLE;
            wrap_cnt   <= '0;
            wrap_pulse <= 1'b0;
            irq        <= 1'b0;
`ifdef DOWN_WRAP_SEQ_CHECK_EN
            seq_err    <= 1'b0;
`endif
        end else begin
            wrap_pulse <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (en) begin
                        prev  <= q_in;
                        state <= ST_TRACK;
                    end
                end
                ST_TRACK, ST_ALERT: begin
                    if (!en) begin
                        state <= ST_IDLE;
                    end else begin
                        prev <= q_in;
                        case (kind)
                            STEP_WRAP: begin
                                wrap_pulse <= 1'b1;
                                if (ack_hit) begin
                                    wrap_cnt <= CNT_ONE;
                                    irq      <= 1'b0;
                                    state    <= ST_TRACK;
                                end else begin
                                    wrap_cnt <= cnt_inc;
                                    if (cnt_inc == LIMIT && wrap_cnt != CNT_MAX) begin
                                        irq   <= 1'b1;
                                        state <= ST_ALERT;
                                    end
                                end
                            end
`ifdef DOWN_WRAP_SEQ_CHECK_EN
                            STEP_ILLEGAL: begin
                                seq_err <= 1'b1;
                                state   <= ST_ERROR;
                            end
`endif
                            default: begin
                                // Hold, decrement, or (without the check) a silent resync.
                                if (ack_hit) begin
                                    wrap_cnt <= '0;
                                    irq      <= 1'b0;
                                    state    <= ST_TRACK;
                                end
                            end
                        endcase
                    end
                end
                default: begin
                    // ERROR is sticky until clr or reset.
                end
            endcase
        end
    end

endmodule

// File: tb/tb_down_wrap_monitor.sv
// Directed self-checking bench for down_wrap_monitor (default parameters).
module tb_down_wrap_monitor;
    import down_cnt_pkg::*;

    localparam int W = 8;

`ifdef DOWN_WRAP_SEQ_CHECK_EN
    localparam bit SEQ_ON = 1'b1;
`else
    localparam bit SEQ_ON = 1'b0;
`endif

    logic         clk     = 1'b0;
    logic         reset   = 1'b1;
    logic         en      = 1'b0;
    logic [1:0]   q_in    = 2'b00;
    logic         clr     = 1'b0;
    logic         irq_ack = 1'b0;
    logic         wrap_pulse;
    logic [W-1:0] wrap_cnt;
    logic         irq;
    logic         seq_err;

    int passed = 0;
    int total  = 0;

    down_wrap_monitor #(.WRAP_W(W), .WRAP_LIMIT(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .q_in       (q_in),
        .clr        (clr),
        .irq_ack    (irq_ack),
        .wrap_pulse (wrap_pulse),
        .wrap_cnt   (wrap_cnt),
        .irq        (irq),
        .seq_err    (seq_err)
    );

    always #5 clk = ~clk;

    // Status vector: {wrap_pulse, wrap_cnt, irq, seq_err}
    function automatic logic [W+2:0] obs();
        return {wrap_pulse, wrap_cnt, irq, seq_err};
    endfunction

    function automatic logic [W+2:0] mk(input bit p, input int c, input bit i, input bit s);
        return {p, W'(c), i, s};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] q, input logic e);
        q_in = q;
        en   = e;
        tick();
    endtask

    task automatic run_wraps(input int n);
        for (int k = 0; k < n; k++) begin
            drive(2'b10, 1'b1);
            drive(2'b01, 1'b1);
            drive(2'b00, 1'b1);
            drive(2'b11, 1'b1);
        end
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        #1;
        total++;
        if (obs() !== mk(0, 0, 0, 0)) $display("FAIL reset_outputs: got %h want %h", obs(), mk(0, 0, 0, 0));
        else passed++;
        total++;
        if (dut.state !== ST_IDLE) $display("FAIL reset_state: got %0d want %0d", dut.state, ST_IDLE);
        else passed++;
        #10 reset = 1'b1;
    endtask

    task automatic test_free_run();
        logic [1:0] seq [4];
        logic [1:0] q;
        bit         p;
        int         wraps;
        seq   = '{2'b11, 2'b10, 2'b01, 2'b00};
        wraps = 0;
        for (int i = 0; i < 17; i++) begin
            q = seq[i % 4];
            drive(q, 1'b1);
            p     = (i > 0) && (q == 2'b11);
            wraps = wraps + int'(p);
            total++;
            if (obs() !== mk(p, wraps, wraps >= 4, 0))
                $display("FAIL free_run[%0d]: got %h want %h", i, obs(), mk(p, wraps, wraps >= 4, 0));
            else passed++;
        end
        total++;
        if (dut.state !== ST_ALERT) $display("FAIL free_run_state: got %0d want %0d", dut.state, ST_ALERT);
        else passed++;
    endtask

    task automatic test_ack_collision();
        drive(2'b10, 1'b1);
        drive(2'b01, 1'b1);
        drive(2'b00, 1'b1);
        total++;
        if (obs() !== mk(0, 4, 1, 0)) $display("FAIL alert_hold: got %h want %h", obs(), mk(0, 4, 1, 0));
        else passed++;
        irq_ack = 1'b1;
        drive(2'b11, 1'b1);
        irq_ack = 1'b0;
        total++;
        if (obs() !== mk(1, 1, 0, 0)) $display("FAIL ack_collision: got %h want %h", obs(), mk(1, 1, 0, 0));
        else passed++;
        total++;
        if (dut.state !== ST_TRACK) $display("FAIL ack_collision_state: got %0d want %0d", dut.state, ST_TRACK);
        else passed++;
    endtask

    task automatic test_ack_saturation();
        irq_ack = 1'b1;
        drive(2'b11, 1'b1);
        irq_ack = 1'b0;
        total++;
        if (obs() !== mk(0, 1, 0, 0)) $display("FAIL ack_outside_alert: got %h want %h", obs(), mk(0, 1, 0, 0));
        else passed++;
        run_wraps(3);
        total++;
        if (obs() !== mk(1, 4, 1, 0)) $display("FAIL realert: got %h want %h", obs(), mk(1, 4, 1, 0));
        else passed++;
        run_wraps(251);
        total++;
        if (obs() !== mk(1, 255, 1, 0)) $display("FAIL reach_max: got %h want %h", obs(), mk(1, 255, 1, 0));
        else passed++;
        run_wraps(1);
        total++;
        if (obs() !== mk(1, 255, 1, 0)) $display("FAIL saturate: got %h want %h", obs(), mk(1, 255, 1, 0));
        else passed++;
        irq_ack = 1'b1;
        drive(2'b11, 1'b1);
        irq_ack = 1'b0;
        total++;
        if (obs() !== mk(0, 0, 0, 0)) $display("FAIL plain_ack: got %h want %h", obs(), mk(0, 0, 0, 0));
        else passed++;
        total++;
        if (dut.state !== ST_TRACK) $display("FAIL plain_ack_state: got %0d want %0d", dut.state, ST_TRACK);
        else passed++;
    endtask

    task automatic test_illegal_step();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        drive(2'b11, 1'b1);
        run_wraps(1);
        drive(2'b10, 1'b1);
        total++;
        if (obs() !== mk(0, 1, 0, 0)) $display("FAIL pre_illegal: got %h want %h", obs(), mk(0, 1, 0, 0));
        else passed++;
        drive(2'b00, 1'b1);
        total++;
        if (obs() !== mk(0, 1, 0, SEQ_ON))
            $display("FAIL illegal_step: got %h want %h", obs(), mk(0, 1, 0, SEQ_ON));
        else passed++;
        drive(2'b11, 1'b1);
        total++;
        if (obs() !== (SEQ_ON ? mk(0, 1, 0, 1) : mk(1, 2, 0, 0)))
            $display("FAIL after_illegal: got %h want %h", obs(), (SEQ_ON ? mk(0, 1, 0, 1) : mk(1, 2, 0, 0)));
        else passed++;
        total++;
        if (dut.state !== (SEQ_ON ? ST_ERROR : ST_TRACK))
            $display("FAIL illegal_state: got %0d want %0d", dut.state, (SEQ_ON ? ST_ERROR : ST_TRACK));
        else passed++;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        total++;
        if (obs() !== mk(0, 0, 0, 0)) $display("FAIL clr_after_illegal: got %h want %h", obs(), mk(0, 0, 0, 0));
        else passed++;
    endtask

    task automatic test_enable_gap();
        drive(2'b11, 1'b1);
        run_wraps(1);
        drive(2'b10, 1'b1);
        drive(2'b01, 1'b1);
        drive(2'b00, 1'b1);
        drive(2'b00, 1'b0);
        drive(2'b00, 1'b0);
        total++;
        if (obs() !== mk(0, 1, 0, 0)) $display("FAIL gap_hold: got %h want %h", obs(), mk(0, 1, 0, 0));
        else passed++;
        total++;
        if (dut.state !== ST_IDLE) $display("FAIL gap_state: got %0d want %0d", dut.state, ST_IDLE);
        else passed++;
        drive(2'b11, 1'b1);
        total++;
        if (obs() !== mk(0, 1, 0, 0)) $display("FAIL gap_reenable: got %h want %h", obs(), mk(0, 1, 0, 0));
        else passed++;
        total++;
        if (dut.state !== ST_TRACK) $display("FAIL gap_reenable_state: got %0d want %0d", dut.state, ST_TRACK);
        else passed++;
    endtask

    task automatic test_async_reset();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        drive(2'b11, 1'b1);
        run_wraps(3);
        total++;
        if (obs() !== mk(1, 3, 0, 0)) $display("FAIL pre_reset: got %h want %h", obs(), mk(1, 3, 0, 0));
        else passed++;
        #3 reset = 1'b0;
        #1;
        total++;
        if (obs() !== mk(0, 0, 0, 0)) $display("FAIL async_reset: got %h want %h", obs(), mk(0, 0, 0, 0));
        else passed++;
        @(posedge clk);
        #2 reset = 1'b1;
        q_in = 2'b11;
        en   = 1'b1;
        tick();
        total++;
        if (obs() !== mk(0, 0, 0, 0)) $display("FAIL post_reset_idle: got %h want %h", obs(), mk(0, 0, 0, 0));
        else passed++;
        total++;
        if (dut.state !== ST_TRACK) $display("FAIL post_reset_state: got %0d want %0d", dut.state, ST_TRACK);
        else passed++;
    endtask

    task automatic test_clr_priority();
        run_wraps(4);
        total++;
        if (obs() !== mk(1, 4, 1, 0)) $display("FAIL clr_setup: got %h want %h", obs(), mk(1, 4, 1, 0));
        else passed++;
        drive(2'b10, 1'b1);
        drive(2'b01, 1'b1);
        drive(2'b00, 1'b1);
        clr     = 1'b1;
        irq_ack = 1'b1;
        drive(2'b11, 1'b1);
        clr     = 1'b0;
        irq_ack = 1'b0;
        total++;
        if (obs() !== mk(0, 0, 0, 0)) $display("FAIL clr_priority: got %h want %h", obs(), mk(0, 0, 0, 0));
        else passed++;
        total++;
        if (dut.state !== ST_IDLE) $display("FAIL clr_priority_state: got %0d want %0d", dut.state, ST_IDLE);
        else passed++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_free_run();
        test_ack_collision();
        test_ack_saturation();
        test_illegal_step();
        test_enable_gap();
        test_async_reset();
        test_clr_priority();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/down_wrap_monitor.md
DOWN_WRAP_MONITOR -- requirements
Module: down_wrap_monitor

Interface
REQ-001 SHALL have parameter WRAP_W, default 8, width of the wrap counter.
REQ-002 SHALL have parameter WRAP_LIMIT, default 4, wrap count that raises irq; legal range 1..2^WRAP_W-1.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port en  input  1  monitor enable.
REQ-006 SHALL have port q_in  input  2  count value from the upstream 2-bit synchronous down counter.
REQ-007 SHALL have port clr  input  1  synchronous clear of all status.
REQ-008 SHALL have port irq_ack  input  1  acknowledge of irq.
REQ-009 SHALL have port wrap_pulse  output  1  one-cycle pulse per detected 00->11 wrap.
REQ-010 SHALL have port wrap_cnt  output  WRAP_W  wraps since last ack or clear.
REQ-011 SHALL have port irq  output  1  level interrupt, wrap limit reached.
REQ-012 SHALL have port seq_err  output  1  sticky illegal-sequence flag.

Function
REQ-013 SHALL implement FSM states IDLE, TRACK, ALERT, ERROR; all outputs registered, one-cycle latency from the q_in sample.
REQ-014 SHALL, in IDLE with en=1, capture q_in into prev and go to TRACK, with no step check that cycle.
REQ-015 SHALL, in TRACK or ALERT with en=1, classify each sample: q_in==prev is a hold (legal); q_in==(prev-1) mod 4 is a step (legal); anything else is illegal; prev updates every enabled cycle.
REQ-016 SHALL treat a step with prev=00, q_in=11 as a wrap: wrap_pulse=1 next cycle, wrap_cnt+1, saturating at 2^WRAP_W-1.
REQ-017 SHALL, when an increment makes wrap_cnt equal WRAP_LIMIT, set irq and enter ALERT; wraps keep counting in ALERT.
REQ-018 SHALL, on irq_ack in ALERT, clear irq, zero wrap_cnt, and return to TRACK; irq_ack outside ALERT is ignored.
REQ-019 SHALL, on irq_ack together with a wrap in ALERT, clear irq and load wrap_cnt=1.
REQ-020 SHALL, on an illegal step, set seq_err and enter ERROR; ERROR freezes wrap_cnt and irq, and wrap_pulse stays 0.
REQ-021 SHALL, on clr=1 in any state, zero wrap_cnt, irq, seq_err, and wrap_pulse, and go to IDLE; clr has priority over all other inputs except reset.
REQ-022 SHALL, on en=0 outside ERROR, go to IDLE next cycle, holding wrap_cnt, irq, and seq_err; wrap_pulse=0.
REQ-023 SHALL, on re-enable, re-prime prev via IDLE, so no wrap or error is inferred across the disabled gap.

Reset
REQ-024 SHALL, while reset=0, asynchronously force state=IDLE, prev=00, wrap_cnt=0, wrap_pulse=0, irq=0, seq_err=0.
REQ-025 SHALL, on reset mid-operation, discard any pending wrap or ack; the first cycle after release behaves as IDLE.

Configuration
REQ-026 SHALL, with macro DOWN_WRAP_SEQ_CHECK_EN defined, implement the illegal-step detection, seq_err, and ERROR state per REQ-015/020.
REQ-027 SHALL, without DOWN_WRAP_SEQ_CHECK_EN, tie seq_err to 0, omit ERROR, and treat illegal steps as a silent prev resync (no wrap counted).

Structure
REQ-028 SHALL take the FSM state enum and the 2-bit count type from shared package down_cnt_pkg.
REQ-029 SHALL instantiate one sub-module, down_step_classify (combinational hold/step/wrap/illegal decode of prev and q_in); FSM and counters live in the top.

Verification
REQ-030 SHALL cover free-run: en=1, q_in cycling 11,10,01,00 for 4 full periods -> one wrap_pulse per 00->11, irq=1 the cycle after the 4th wrap, wrap_cnt=4.
REQ-031 SHALL cover ack collision: irq=1, irq_ack coincident with a wrap -> irq=0, wrap_cnt=1, state TRACK.
REQ-032 SHALL cover an illegal step: q_in 10->00 -> seq_err=1 next cycle, wrap_cnt frozen; with the macro off -> seq_err=0, counting continues.
REQ-033 SHALL cover an enable gap: en=0 at q_in=00, en=1 at q_in=11 -> no wrap_pulse, wrap_cnt unchanged.
REQ-034 SHALL cover async reset: reset=0 asserted mid-cycle with wrap_cnt=3 -> all outputs 0 immediately, without waiting for clk.
REQ-035 SHALL cover clr priority: clr=1 with a wrap and irq_ack in the same cycle -> wrap_cnt=0, irq=0, state IDLE.
